ika87ad_mcseq: RTL and testbench

- Microcode sequencer: the consumer side of the microcode ROM interface.
- Accepts a start address from the instruction decoder and issues ROM read ticks/addresses.
- Captures each 18-bit microword, presents it to the datapath, and drives the bus-cycle request encoded in the word's low 2 bits.
- Steps through consecutive words until an RD4 (next-opcode fetch) word completes, then pulses o_IRD so the decoder can load the next instruction.

---
 rtl/ika87ad_mcseq.sv | 176 +++++++++++++++++
 tb/tb_ika87ad_mcseq.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ika87ad_mcseq.sv
// rtl/ika87ad_mcseq.sv - microcode sequencer, consumer side of the microcode ROM interface
//
// Fetches microwords from the ROM starting at the decoder-supplied entry
// address, presents each word to the datapath, requests the bus cycle encoded
// in the word's low 2 bits and steps to the next word until an RD4 word
// completes, then pulses o_IRD.
//
// Ports:
//   i_CLK, i_RST_n           clock, asynchronous active-low reset
//   i_START, i_START_ADDR    decoder start strobe and microcode entry address
//   o_MCROM_READ_TICK        ROM read enable (one cycle per word)
//   o_MCROM_ADDR             ROM address
//   i_MCROM_DATA             ROM word, valid the cycle after the tick
//   o_MC_WORD, o_MC_VALID    executing microword and its valid flag
//   o_BUSCYC, o_BUSCYC_REQ   bus cycle type (00 IDLE, 01 RD3, 10 WR3, 11 RD4) and request
//   i_BUS_DONE               bus cycle complete strobe
//   o_IRD                    instruction-end pulse
//   o_BUSY                   sequencer not idle
//   o_FAULT                  watchdog abort pulse
//
// Optional feature macro: IKA87AD_MCSEQ_WDT_EN enables the MAX_STEPS watchdog.

module ika87ad_mcseq #(
    parameter int MAX_STEPS = 4,
    parameter int ADDR_W    = 8
) (
    input  logic              i_CLK,
    input  logic              i_RST_n,
    input  logic              i_START,
    input  logic [ADDR_W-1:0] i_START_ADDR,
    output logic              o_MCROM_READ_TICK,
    output logic [ADDR_W-1:0] o_MCROM_ADDR,
    input  logic [17:0]       i_MCROM_DATA,
    output logic [17:0]       o_MC_WORD,
    output logic              o_MC_VALID,
    output logic [1:0]        o_BUSCYC,
    output logic              o_BUSCYC_REQ,
    input  logic              i_BUS_DONE,
    output logic              o_IRD,
    output logic              o_BUSY,
    output logic              o_FAULT
);

    localparam int STEP_W = (MAX_STEPS < 1) ? 1 : $clog2(MAX_STEPS + 1);
    localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(MAX_STEPS);

`ifdef IKA87AD_MCSEQ_WDT_EN
    localparam bit WDT_EN = 1'b1;
`else
    localparam bit WDT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_EXEC,
        S_END
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [17:0]       word_q, word_d;
    logic              tick_q, tick_d;
    logic              valid_q, valid_d;
    logic [1:0]        buscyc_q, buscyc_d;
    logic              req_q, req_d;
    logic              ird_q, ird_d;
    logic              busy_q, busy_d;
    logic              fault_q, fault_d;
    logic              exec_done;
    logic              wdt_hit;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        step_d  = step_q;
        word_d  = word_q;
        fault_d = 1'b0;

        // IDLE-coded words finish immediately; others wait for the bus unit.
        exec_done = (word_q[1:0] == 2'b00) || i_BUS_DONE;
        // Constant-false without the watchdog macro, so o_FAULT stays 0.
        wdt_hit   = WDT_EN && (step_q == STEP_MAX);

        case (state_q)
            S_IDLE: begin
                if (i_START) begin
                    addr_d  = i_START_ADDR;
                    step_d  = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                word_d  = i_MCROM_DATA;
                if (step_q != STEP_MAX) begin
                    step_d = step_q + STEP_W'(1);
                end
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (exec_done) begin
                    if (word_q[1:0] == 2'b11) begin
                        state_d = S_END;
                    end else if (wdt_hit) begin
                        state_d = S_END;
                        fault_d = 1'b1;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_END: begin
                // Accepting a start here lets back-to-back instructions run without a gap.
                if (i_START) begin
                    addr_d  = i_START_ADDR;
                    step_d  = '0;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they come straight from flops.
        tick_d   = (state_d == S_FETCH);
        valid_d  = (state_d == S_EXEC);
        buscyc_d = valid_d ? word_d[1:0] : 2'b00;
        req_d    = valid_d && (word_d[1:0] != 2'b00);
        ird_d    = (state_d == S_END);
        busy_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            step_q   <= '0;
            word_q   <= '0;
            tick_q   <= 1'b0;
            valid_q  <= 1'b0;
            buscyc_q <= 2'b00;
            req_q    <= 1'b0;
            ird_q    <= 1'b0;
            busy_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            step_q   <= step_d;
            word_q   <= word_d;
            tick_q   <= tick_d;
            valid_q  <= valid_d;
            buscyc_q <= buscyc_d;
            req_q    <= req_d;
            ird_q    <= ird_d;
            busy_q   <= busy_d;
            fault_q  <= fault_d;
        end
    end

    assign o_MCROM_READ_TICK = tick_q;
    assign o_MCROM_ADDR      = addr_q;
    assign o_MC_WORD         = word_q;
    assign o_MC_VALID        = valid_q;
    assign o_BUSCYC          = buscyc_q;
    assign o_BUSCYC_REQ      = req_q;
    assign o_IRD             = ird_q;
    assign o_BUSY            = busy_q;
    assign o_FAULT           = fault_q;

endmodule

// File: tb/tb_ika87ad_mcseq.sv
// tb/tb_ika87ad_mcseq.sv - scoreboard testbench for ika87ad_mcseq

module tb_ika87ad_mcseq;

    logic        i_CLK = 1'b0;
    logic        i_RST_n = 1'b0;
    logic        i_START = 1'b0;
    logic [7:0]  i_START_ADDR = 8'h00;
    logic        o_MCROM_READ_TICK;
    logic [7:0]  o_MCROM_ADDR;
    logic [17:0] i_MCROM_DATA = 18'h0;
    logic [17:0] o_MC_WORD;
    logic        o_MC_VALID;
    logic [1:0]  o_BUSCYC;
    logic        o_BUSCYC_REQ;
    logic        i_BUS_DONE = 1'b0;
    logic        o_IRD;
    logic        o_BUSY;
    logic        o_FAULT;

    int total = 0;
    int bad = 0;

    logic [17:0] rom [256];
    logic [7:0]  q_tick [$];
    logic [17:0] q_exec [$];
    logic        q_ird [$];

    int   bus_lat = 0;
    int   req_cnt = 0;
    logic valid_prev = 1'b0;
    logic [7:0]  mon_addr;
    logic [17:0] mon_word;
    logic        mon_fault;

    ika87ad_mcseq #(.MAX_STEPS(4), .ADDR_W(8)) dut (
        .i_CLK             (i_CLK),
        .i_RST_n           (i_RST_n),
        .i_START           (i_START),
        .i_START_ADDR      (i_START_ADDR),
        .o_MCROM_READ_TICK (o_MCROM_READ_TICK),
        .o_MCROM_ADDR      (o_MCROM_ADDR),
        .i_MCROM_DATA      (i_MCROM_DATA),
        .o_MC_WORD         (o_MC_WORD),
        .o_MC_VALID        (o_MC_VALID),
        .o_BUSCYC          (o_BUSCYC),
        .o_BUSCYC_REQ      (o_BUSCYC_REQ),
        .i_BUS_DONE        (i_BUS_DONE),
        .o_IRD             (o_IRD),
        .o_BUSY            (o_BUSY),
        .o_FAULT           (o_FAULT)
    );

    always #5 i_CLK = ~i_CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string nm);
        total++;
        bad++;
        $display("FAIL %s actual=event required=none t=%0t", nm, $time);
    endtask

    // ROM responder: word appears after the tick and holds until the next one.
    always @(negedge i_CLK) begin
        if (o_MCROM_READ_TICK) i_MCROM_DATA = rom[o_MCROM_ADDR];
    end

    // Bus unit: done pulse bus_lat cycles after REQ rises (0 = same cycle).
    always @(negedge i_CLK) begin
        i_BUS_DONE = 1'b0;
        if (o_BUSCYC_REQ) begin
            if (req_cnt == bus_lat) i_BUS_DONE = 1'b1;
            req_cnt++;
        end else begin
            req_cnt = 0;
        end
    end

    // Monitor: pops scoreboard entries whenever the DUT presents an event.
    always @(negedge i_CLK) begin
        if (i_RST_n) begin
            if (o_MCROM_READ_TICK) begin
                if (q_tick.size() == 0) unexpected("tick_unexpected");
                else begin
                    mon_addr = q_tick.pop_front();
                    chk("tick_addr", 32'(o_MCROM_ADDR), 32'(mon_addr));
                end
            end
            if (o_MC_VALID && !valid_prev) begin
                if (q_exec.size() == 0) unexpected("exec_unexpected");
                else begin
                    mon_word = q_exec.pop_front();
                    chk("exec_word", 32'(o_MC_WORD), 32'(mon_word));
                    chk("exec_buscyc", 32'(o_BUSCYC), 32'(mon_word[1:0]));
                    chk("exec_req", 32'(o_BUSCYC_REQ), 32'(mon_word[1:0] != 2'b00));
                end
            end
            if (o_IRD) begin
                if (q_ird.size() == 0) unexpected("ird_unexpected");
                else begin
                    mon_fault = q_ird.pop_front();
                    chk("ird_fault", 32'(o_FAULT), 32'(mon_fault));
                    chk("ird_valid_low", 32'(o_MC_VALID), 32'd0);
                end
            end
            chk("req_outside_exec", 32'(o_BUSCYC_REQ & ~o_MC_VALID), 32'd0);
            chk("fault_without_ird", 32'(o_FAULT & ~o_IRD), 32'd0);
        end
        valid_prev = o_MC_VALID;
    end

    task automatic put(input logic [7:0] a, input logic [1:0] code, input logic [7:0] tag);
        rom[a] = {tag, a, code};
    endtask

    task automatic exp_word(input logic [7:0] a);
        q_tick.push_back(a);
        q_exec.push_back(rom[a]);
    endtask

    // Called at a negedge; START is sampled on the following posedge.
    task automatic pulse_start(input logic [7:0] a);
        i_START = 1'b1;
        i_START_ADDR = a;
        @(negedge i_CLK);
        i_START = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] a);
        @(negedge i_CLK);
        pulse_start(a);
    endtask

    // Entered at the negedge of the first cycle after START was sampled (n=1).
    task automatic wait_ird(input string nm, output int n, output int idle);
        n = 1;
        idle = 0;
        while (!o_IRD && n < 200) begin
            if (!o_BUSY) idle++;
            @(negedge i_CLK);
            n++;
        end
        chk({nm, "_ird_seen"}, 32'(o_IRD), 32'd1);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (o_BUSY && k < 100) begin
            @(negedge i_CLK);
            k++;
        end
        chk("idle_reached", 32'(o_BUSY), 32'd0);
    endtask

    initial begin
        int n;
        int idle1;
        int idle2;
        int k;

        for (int i = 0; i < 256; i++) rom[i] = 18'h0;

        #7;
        chk("rst_tick", 32'(o_MCROM_READ_TICK), 32'd0);
        chk("rst_addr", 32'(o_MCROM_ADDR), 32'd0);
        chk("rst_word", 32'(o_MC_WORD), 32'd0);
        chk("rst_valid", 32'(o_MC_VALID), 32'd0);
        chk("rst_buscyc", 32'(o_BUSCYC), 32'd0);
        chk("rst_req", 32'(o_BUSCYC_REQ), 32'd0);
        chk("rst_ird", 32'(o_IRD), 32'd0);
        chk("rst_busy", 32'(o_BUSY), 32'd0);
        chk("rst_fault", 32'(o_FAULT), 32'd0);
        @(negedge i_CLK);
        @(negedge i_CLK);
        i_RST_n = 1'b1;

        // 1: four words 01,01,10,11, done two cycles after each REQ.
        bus_lat = 2;
        put(8'h20, 2'b01, 8'h11); put(8'h21, 2'b01, 8'h12);
        put(8'h22, 2'b10, 8'h13); put(8'h23, 2'b11, 8'h14);
        for (int i = 0; i < 4; i++) exp_word(8'h20 + 8'(i));
        q_ird.push_back(1'b0);
        do_start(8'h20);
        wait_ird("t1", n, idle1);
        chk("t1_latency", n, 21);
        chk("t1_busy_at_ird", 32'(o_BUSY), 32'd1);
        @(negedge i_CLK);
        chk("t1_busy_after", 32'(o_BUSY), 32'd0);

        // 2: IDLE word then RD4, done in the same cycle as REQ.
        bus_lat = 0;
        put(8'h00, 2'b00, 8'h21); put(8'h01, 2'b11, 8'h22);
        exp_word(8'h00); exp_word(8'h01);
        q_ird.push_back(1'b0);
        do_start(8'h00);
        wait_ird("t2", n, idle1);
        chk("t2_latency", n, 7);
        wait_idle();

        // 3: address wrap FF -> 00.
        bus_lat = 1;
        put(8'hFF, 2'b01, 8'h31); put(8'h00, 2'b11, 8'h32);
        exp_word(8'hFF); exp_word(8'h00);
        q_ird.push_back(1'b0);
        do_start(8'hFF);
        wait_ird("t3", n, idle1);
        chk("t3_latency", n, 9);
        wait_idle();

        // 4: second START during EXEC is ignored.
        bus_lat = 2;
        put(8'h30, 2'b01, 8'h41); put(8'h31, 2'b11, 8'h42); put(8'h40, 2'b10, 8'h43);
        exp_word(8'h30); exp_word(8'h31);
        q_ird.push_back(1'b0);
        do_start(8'h30);
        k = 0;
        while (!o_MC_VALID && k < 20) begin
            @(negedge i_CLK);
            k++;
        end
        chk("t4_in_exec", 32'(o_MC_VALID), 32'd1);
        pulse_start(8'h40);
        wait_ird("t4", n, idle1);
        wait_idle();

        // 5: START during S_END goes straight to FETCH.
        bus_lat = 0;
        put(8'h50, 2'b11, 8'h51); put(8'h10, 2'b11, 8'h52);
        exp_word(8'h50);
        q_ird.push_back(1'b0);
        exp_word(8'h10);
        q_ird.push_back(1'b0);
        do_start(8'h50);
        wait_ird("t5a", n, idle1);
        chk("t5_min_latency", n, 4);
        pulse_start(8'h10);
        chk("t5_tick", 32'(o_MCROM_READ_TICK), 32'd1);
        chk("t5_addr", 32'(o_MCROM_ADDR), 32'h10);
        chk("t5_busy", 32'(o_BUSY), 32'd1);
        wait_ird("t5b", n, idle2);
        chk("t5b_latency", n, 4);
        chk("t5_busy_stays", idle1 + idle2, 0);
        wait_idle();

        // 6: reset while REQ is held.
        bus_lat = 1000;
        put(8'h60, 2'b10, 8'h61);
        exp_word(8'h60);
        do_start(8'h60);
        k = 0;
        while (!o_BUSCYC_REQ && k < 20) begin
            @(negedge i_CLK);
            k++;
        end
        @(negedge i_CLK);
        @(negedge i_CLK);
        chk("t6_req_held", 32'(o_BUSCYC_REQ), 32'd1);
        #2;
        i_RST_n = 1'b0;
        #1;
        chk("t6_req_drop", 32'(o_BUSCYC_REQ), 32'd0);
        chk("t6_busy_drop", 32'(o_BUSY), 32'd0);
        chk("t6_valid_drop", 32'(o_MC_VALID), 32'd0);
        chk("t6_no_ird", 32'(o_IRD), 32'd0);
        @(negedge i_CLK);
        @(negedge i_CLK);
        i_RST_n = 1'b1;
        bus_lat = 0;
        @(negedge i_CLK);
        @(negedge i_CLK);
        chk("t6_idle_after", 32'(o_BUSY), 32'd0);

`ifdef IKA87AD_MCSEQ_WDT_EN
        // 7: watchdog aborts after the 4th non-RD4 word.
        for (int i = 0; i < 5; i++) put(8'h70 + 8'(i), 2'b01, 8'h71);
        for (int i = 0; i < 4; i++) exp_word(8'h70 + 8'(i));
        q_ird.push_back(1'b1);
        do_start(8'h70);
        wait_ird("t7", n, idle1);
        chk("t7_latency", n, 13);
        chk("t7_fault", 32'(o_FAULT), 32'd1);
        wait_idle();
`endif

        for (int i = 0; i < 5; i++) @(negedge i_CLK);
        chk("q_tick_empty", q_tick.size(), 0);
        chk("q_exec_empty", q_exec.size(), 0);
        chk("q_ird_empty", q_ird.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
